reg_file_bank: RTL and testbench

//  Parametrised multi-read-port register file for the single-cycle/pipelined CPU datapath.

---
 rtl/reg_file_pkg.sv | 17 +
 rtl/rf_clear_seq.sv | 71 +++++++
 rtl/reg_file_bank.sv | 106 ++++++++++
 tb/tb_reg_file_bank.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module : reg_file_pkg
// Brief  : Shared types and constants for the register file bank.
// Rev    : 1.0
// ============================================================================
package reg_file_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

  localparam int RF_ZERO_ADDR = 0;

endpackage
`default_nettype wire

// File: rtl/rf_clear_seq.sv
`default_nettype none
// ============================================================================
// Module : rf_clear_seq
// Brief  : Clear-sweep sequencer; walks every entry once after reset or request.
// Rev    : 1.0
// ============================================================================
module rf_clear_seq #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);
  import reg_file_pkg::*;

  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    busy_d    = busy_q;
    case (state_q)
      RF_IDLE: begin
        if (clear_req) begin
          state_d   = RF_CLEAR;
          clr_ptr_d = '0;
          busy_d    = 1'b1;
        end
      end
      RF_CLEAR: begin
        if (clr_ptr_q == C_LAST) begin
          state_d   = RF_IDLE;
          clr_ptr_d = '0;
          busy_d    = 1'b0;
        end else begin
          clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = RF_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RF_CLEAR;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign clr_we   = (state_q == RF_CLEAR);
  assign clr_addr = clr_ptr_q;

endmodule
`default_nettype wire

// File: rtl/reg_file_bank.sv
`default_nettype none
// ============================================================================
// Module : reg_file_bank
// Brief  : Multi-read-port register file with zero register, bypass and clear sweep.
// Rev    : 1.0
// ============================================================================
module reg_file_bank #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_req,
  input  logic                     reg_write,
  input  logic [ADDR_W-1:0]        write_addr,
  input  logic [DATA_W-1:0]        write_data,
  input  logic [NUM_RD*ADDR_W-1:0] read_addr,
  output logic [NUM_RD*DATA_W-1:0] read_data,
  output logic                     busy,
  output logic                     err
);
  import reg_file_pkg::*;

  localparam logic [ADDR_W:0]   C_DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] C_ZERO_A  = ADDR_W'(RF_ZERO_ADDR);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_in_range, wr_is_zero, wr_legal;
  logic              err_q, err_d;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_q [DEPTH];

  rf_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk       (clk),
    .reset     (reset),
    .clear_req (clear_req),
    .busy      (busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  always_comb begin
    wr_in_range = ({1'b0, write_addr} < C_DEPTH_X);
    wr_is_zero  = (ZERO_REG != 0) && (write_addr == C_ZERO_A);
    // A pending clear request outranks a same-cycle write.
    wr_legal    = reg_write && !busy && !clear_req && wr_in_range && !wr_is_zero;
    err_d       = reg_write && (busy || clear_req || !wr_in_range);
  end

  // busy and clr_we are both derived from the CLEAR state, so the sources never collide.
  always_comb begin
    mem_we    = clr_we | wr_legal;
    mem_waddr = clr_we ? clr_addr : write_addr;
    mem_wdata = clr_we ? '0 : write_data;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = read_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      rd = mem_q[ra];
      if (busy) begin
        rd = '0;
      end else if ({1'b0, ra} >= C_DEPTH_X) begin
        rd = '0;
      end else if ((ZERO_REG != 0) && (ra == C_ZERO_A)) begin
        rd = '0;
      end else if ((BYPASS != 0) && wr_legal && (write_addr == ra)) begin
        rd = write_data;
      end
    end

    assign read_data[i*DATA_W +: DATA_W] = rd;
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_bank.sv
`default_nettype none
// ============================================================================
// Module : tb_reg_file_bank
// Brief  : Randomised and directed bench for reg_file_bank against a behavioural model.
// Rev    : 1.0
// ============================================================================
module tb_reg_file_bank;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: default parameters (32 x 32, 2 read ports)
  logic        reset, clear_req, reg_write, busy, err;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [9:0]  read_addr;
  logic [63:0] read_data;

  // Second instance: DEPTH=20, DATA_W=16, 4 read ports
  logic        b_reset, b_clear_req, b_reg_write, b_busy, b_err;
  logic [4:0]  b_write_addr;
  logic [15:0] b_write_data;
  logic [19:0] b_read_addr;
  logic [63:0] b_read_data;

  int checks = 0;
  int errors = 0;

  reg_file_bank u_dut (
    .clk        (clk),
    .reset      (reset),
    .clear_req  (clear_req),
    .reg_write  (reg_write),
    .write_addr (write_addr),
    .write_data (write_data),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .busy       (busy),
    .err        (err)
  );

  reg_file_bank #(
    .DATA_W (16),
    .DEPTH  (20),
    .NUM_RD (4)
  ) u_dut_b (
    .clk        (clk),
    .reset      (b_reset),
    .clear_req  (b_clear_req),
    .reg_write  (b_reg_write),
    .write_addr (b_write_addr),
    .write_data (b_write_data),
    .read_addr  (b_read_addr),
    .read_data  (b_read_data),
    .busy       (b_busy),
    .err        (b_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: a sweep is a 32-cycle blackout; the array reads as all-zero afterwards.
  logic [31:0] m_mem [32];
  int          m_busy_rem = 0;
  logic        m_err = 1'b0;
  bit          m_started = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_started = 1'b1;
      m_busy_rem = 32;
      m_err = 1'b0;
      foreach (m_mem[k]) m_mem[k] = 32'h0;
    end else if (m_busy_rem > 0) begin
      m_err = reg_write;
      m_busy_rem = m_busy_rem - 1;
    end else if (clear_req) begin
      m_err = reg_write;
      m_busy_rem = 32;
      foreach (m_mem[k]) m_mem[k] = 32'h0;
    end else begin
      m_err = 1'b0;
      if (reg_write && write_addr != 5'd0) m_mem[write_addr] = write_data;
    end
  end

  function automatic logic [31:0] exp_read(input logic [4:0] ra);
    if (m_busy_rem > 0 || ra == 5'd0) return 32'h0;
    if (reg_write && !clear_req && write_addr != 5'd0 && write_addr == ra) return write_data;
    return m_mem[ra];
  endfunction

  always @(negedge clk) begin
    if (m_started) begin
      chk("busy", {63'h0, busy}, {63'h0, (m_busy_rem > 0)});
      chk("err", {63'h0, err}, {63'h0, m_err});
      chk("rd0", {32'h0, read_data[31:0]}, {32'h0, exp_read(read_addr[4:0])});
      chk("rd1", {32'h0, read_data[63:32]}, {32'h0, exp_read(read_addr[9:5])});
    end
  end

  initial begin
    int n;
    reset = 1'b1; clear_req = 1'b0; reg_write = 1'b0;
    write_addr = '0; write_data = '0; read_addr = '0;
    b_reset = 1'b1; b_clear_req = 1'b0; b_reg_write = 1'b0;
    b_write_addr = '0; b_write_data = '0; b_read_addr = '0;
    tick();
    reset = 1'b0; b_reset = 1'b0;

    // Busy window after a one-cycle reset
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy === 1'b1) n++;
    end
    chk("busy_len_after_reset", 64'(n), 64'd32);
    tick();

    // Same-cycle bypass, then the stored value
    reg_write = 1'b1; write_addr = 5'd5; write_data = 32'hDEADBEEF;
    read_addr = {5'd0, 5'd5};
    @(negedge clk);
    chk("bypass_r5", {32'h0, read_data[31:0]}, 64'hDEADBEEF);
    tick();
    reg_write = 1'b0;
    @(negedge clk);
    chk("stored_r5", {32'h0, read_data[31:0]}, 64'hDEADBEEF);
    tick();

    // Zero register
    reg_write = 1'b1; write_addr = 5'd0; write_data = 32'h12345678; read_addr = {5'd5, 5'd0};
    @(negedge clk);
    chk("r0_bypass_blocked", {32'h0, read_data[31:0]}, 64'h0);
    tick();
    reg_write = 1'b0;
    @(negedge clk);
    chk("r0_reads_zero", {32'h0, read_data[31:0]}, 64'h0);
    chk("r0_no_err", {63'h0, err}, 64'h0);

    // Fill, sweep, illegal write mid-sweep
    for (int i = 1; i < 32; i++) begin
      tick();
      reg_write = 1'b1; write_addr = 5'(i); write_data = 32'(i);
    end
    tick();
    reg_write = 1'b0; read_addr = {5'd31, 5'd3};
    @(negedge clk);
    chk("fill_r3", {32'h0, read_data[31:0]}, 64'd3);
    chk("fill_r31", {32'h0, read_data[63:32]}, 64'd31);
    tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (10) tick();
    reg_write = 1'b1; write_addr = 5'd3; write_data = 32'd7;
    tick();
    reg_write = 1'b0;
    @(negedge clk);
    chk("err_write_in_sweep", {63'h0, err}, 64'h1);
    for (int k = 0; k < 40 && busy !== 1'b0; k++) tick();
    @(negedge clk);
    chk("sweep_done", {63'h0, busy}, 64'h0);
    chk("swept_r3", {32'h0, read_data[31:0]}, 64'h0);
    chk("swept_r31", {32'h0, read_data[63:32]}, 64'h0);
    tick();

    // Reset mid-sweep restarts the full window
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (15) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy === 1'b1) n++;
    end
    chk("busy_len_after_midsweep_reset", 64'(n), 64'd32);

    // Second instance: out-of-range write and four read ports
    tick();
    b_reg_write = 1'b1; b_write_addr = 5'd2; b_write_data = 16'hAAAA;
    tick();
    b_write_addr = 5'd3; b_write_data = 16'h5555;
    tick();
    b_write_addr = 5'd25; b_write_data = 16'h1234;
    tick();
    b_reg_write = 1'b0;
    b_read_addr = {5'd2, 5'd0, 5'd3, 5'd2};
    @(negedge clk);
    chk("b_err_oob", {63'h0, b_err}, 64'h1);
    chk("b_reads", b_read_data, 64'hAAAA_0000_5555_AAAA);
    tick();
    @(negedge clk);
    chk("b_err_clears", {63'h0, b_err}, 64'h0);
    b_read_addr = {5'd25, 5'd19, 5'd0, 5'd3};
    @(negedge clk);
    chk("b_oob_and_untouched", b_read_data, 64'h0000_0000_0000_5555);

    // Randomised traffic against the model
    for (int c = 0; c < 2500; c++) begin
      tick();
      reset      = ($urandom_range(0, 299) == 0);
      clear_req  = ($urandom_range(0, 59) == 0);
      reg_write  = $urandom_range(0, 1) == 1;
      write_addr = 5'($urandom_range(0, 31));
      write_data = $urandom;
      read_addr[4:0] = ($urandom_range(0, 2) == 0) ? write_addr : 5'($urandom_range(0, 31));
      read_addr[9:5] = 5'($urandom_range(0, 31));
    end
    tick();
    reset = 1'b0; clear_req = 1'b0; reg_write = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
